// File: rtl/alu_op_responder.sv
// Handshaked sequential ALU: one command in flight, single-cycle logic ops, WIDTH-cycle MUL/DIV.
// Optional out_carry/out_zero flag outputs are built only when ALU_FLAGS_EN is defined.
module alu_op_responder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out
`ifdef ALU_FLAGS_EN
  ,
  output logic             out_carry,
  output logic             out_zero
`endif
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpMul  = 4'd2;
  localparam logic [3:0] OpDiv  = 4'd3;
  localparam logic [3:0] OpShl  = 4'd4;
  localparam logic [3:0] OpShr  = 4'd5;
  localparam logic [3:0] OpRol  = 4'd6;
  localparam logic [3:0] OpRor  = 4'd7;
  localparam logic [3:0] OpAnd  = 4'd8;
  localparam logic [3:0] OpOr   = 4'd9;
  localparam logic [3:0] OpXor  = 4'd10;
  localparam logic [3:0] OpNor  = 4'd11;
  localparam logic [3:0] OpNand = 4'd12;
  localparam logic [3:0] OpXnor = 4'd13;
  localparam logic [3:0] OpGt   = 4'd14;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         sel_q;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d, prod_step;
  logic [WIDTH-1:0]   rem_q, rem_d, rem_step;
  logic [WIDTH-1:0]   quot_q, quot_d, quot_step;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic               iter_op;
  logic               finish;
  logic [WIDTH-1:0]   res;
  logic [WIDTH-1:0]   out_q;

  assign iter_op = (sel_q == OpMul) || (sel_q == OpDiv);

  // One shift-add / restoring-divide step per EXEC cycle; the final step feeds the result mux.
  always_comb begin
    prod_step = prod_q + (b_q[cnt_q] ? ({{WIDTH{1'b0}}, a_q} << cnt_q) : '0);
    div_shift = {rem_q, a_q[LastCnt - cnt_q]};
    div_ge    = div_shift >= {1'b0, b_q};
    rem_step  = div_ge ? (div_shift[WIDTH-1:0] - b_q) : div_shift[WIDTH-1:0];
    quot_step = {quot_q[WIDTH-2:0], div_ge};
  end

  always_comb begin
    res = '0;
    case (sel_q)
      OpAdd:   res = a_q + b_q;
      OpSub:   res = a_q - b_q;
      OpMul:   res = prod_step[WIDTH-1:0];
      OpDiv:   res = quot_step;
      OpShl:   res = {a_q[WIDTH-2:0], 1'b0};
      OpShr:   res = {1'b0, a_q[WIDTH-1:1]};
      OpRol:   res = {a_q[WIDTH-2:0], a_q[WIDTH-1]};
      OpRor:   res = {a_q[0], a_q[WIDTH-1:1]};
      OpAnd:   res = a_q & b_q;
      OpOr:    res = a_q | b_q;
      OpXor:   res = a_q ^ b_q;
      OpNor:   res = ~(a_q | b_q);
      OpNand:  res = ~(a_q & b_q);
      OpXnor:  res = ~(a_q ^ b_q);
      OpGt:    res = {{(WIDTH-1){1'b0}}, a_q > b_q};
      default: res = {{(WIDTH-1){1'b0}}, a_q == b_q};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    rem_d     = rem_q;
    quot_d    = quot_q;
    finish    = 1'b0;
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StExec;
          cnt_d   = '0;
          prod_d  = '0;
          rem_d   = '0;
          quot_d  = '0;
        end
      end
      StExec: begin
        prod_d = prod_step;
        rem_d  = rem_step;
        quot_d = quot_step;
        if (!iter_op || (cnt_q == LastCnt)) begin
          finish  = 1'b1;
          state_d = StDone;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      if ((state_q == StIdle) && in_valid) begin
        a_q   <= A;
        b_q   <= B;
        sel_q <= sel;
      end
      if (finish) out_q <= res;
    end
  end

  assign out = out_q;

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_full;
  logic           carry_c;
  logic           carry_q, zero_q;

  always_comb begin
    add_full = {1'b0, a_q} + {1'b0, b_q};
    carry_c  = 1'b0;
    case (sel_q)
      OpAdd:        carry_c = add_full[WIDTH];
      OpSub:        carry_c = a_q < b_q;
      OpMul:        carry_c = |prod_step[2*WIDTH-1:WIDTH];
      OpDiv:        carry_c = (b_q == '0);
      OpShl, OpRol: carry_c = a_q[WIDTH-1];
      OpShr, OpRor: carry_c = a_q[0];
      default:      carry_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else if (finish) begin
      carry_q <= carry_c;
      zero_q  <= (res == '0);
    end
  end

  assign out_carry = carry_q;
  assign out_zero  = zero_q;
`endif

endmodule

// File: tb/tb_alu_op_responder.sv
// Directed self-checking bench for alu_op_responder (WIDTH=8); flag checks only with ALU_FLAGS_EN.
module tb_alu_op_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [3:0] sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
`ifdef ALU_FLAGS_EN
  logic       out_carry, out_zero;
`endif

  int total = 0;
  int bad   = 0;
  logic ready_leak;

  always #5 clk = ~clk;

  alu_op_responder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out)
`ifdef ALU_FLAGS_EN
    ,
    .out_carry (out_carry),
    .out_zero  (out_zero)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where out_valid is seen (or the bound expires).
  task automatic run_op(input logic [7:0] a_in, input logic [7:0] b_in, input logic [3:0] s,
                        output logic [7:0] res, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = a_in; b = b_in; sel = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    ready_leak = 1'b0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (!out_valid && in_ready) ready_leak = 1'b1;
    end while (!out_valid && lat < 40);
    res = out;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_tab [16];
    logic [7:0] r;
    int         lat;

    exp_tab = '{8'h0C, 8'h08, 8'h14, 8'h05, 8'h14, 8'h05, 8'h14, 8'h05,
                8'h02, 8'h0A, 8'h08, 8'hF5, 8'hFD, 8'hF7, 8'h01, 8'h00};
    rst = 1'b1; in_valid = 1'b1; a = 8'h11; b = 8'h22; sel = 4'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", {24'd0, out}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Opcode sweep with A=0x0A, B=0x02, including latency per class.
    for (int i = 0; i < 16; i++) begin
      run_op(8'h0A, 8'h02, 4'(i), r, lat);
      check($sformatf("sweep_sel%0d", i), {24'd0, r}, {24'd0, exp_tab[i]});
      check($sformatf("latency_sel%0d", i), lat, (i == 2 || i == 3) ? 32'd8 : 32'd1);
      check($sformatf("busy_ready_sel%0d", i), {31'd0, ready_leak}, 32'd0);
    end

    // Wrap-around cases.
    run_op(8'hF6, 8'h0A, 4'd0, r, lat);
    check("wrap_add", {24'd0, r}, 32'h00);
`ifdef ALU_FLAGS_EN
    check("wrap_add_carry", {31'd0, out_carry}, 32'd1);
    check("wrap_add_zero", {31'd0, out_zero}, 32'd1);
`endif
    run_op(8'hF6, 8'h0A, 4'd1, r, lat);
    check("wrap_sub", {24'd0, r}, 32'hEC);
`ifdef ALU_FLAGS_EN
    check("wrap_sub_carry", {31'd0, out_carry}, 32'd0);
    check("wrap_sub_zero", {31'd0, out_zero}, 32'd0);
`endif
    run_op(8'hF6, 8'h0A, 4'd2, r, lat);
    check("wrap_mul", {24'd0, r}, 32'h9C);
`ifdef ALU_FLAGS_EN
    check("wrap_mul_carry", {31'd0, out_carry}, 32'd1);
`endif
    run_op(8'hF6, 8'h0A, 4'd3, r, lat);
    check("wrap_div", {24'd0, r}, 32'h18);
    run_op(8'hFF, 8'h10, 4'd3, r, lat);
    check("div_ff_by_10", {24'd0, r}, 32'h0F);

    // Divide by zero.
    run_op(8'h37, 8'h00, 4'd3, r, lat);
    check("div0_out", {24'd0, r}, 32'hFF);
    check("div0_latency", lat, 32'd8);
`ifdef ALU_FLAGS_EN
    check("div0_carry", {31'd0, out_carry}, 32'd1);
`endif

    // Backpressure: hold the result for 5 cycles while in_valid pulses are ignored.
    @(negedge clk);
    out_ready = 1'b0;
    run_op(8'h03, 8'h04, 4'd0, r, lat);
    check("bp_first", {24'd0, r}, 32'h07);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      a = 8'hA0 + 8'(i);
      @(posedge clk);
      @(negedge clk);
      check($sformatf("bp_valid_%0d", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("bp_out_%0d", i), {24'd0, out}, 32'h07);
      check($sformatf("bp_ready_%0d", i), {31'd0, in_ready}, 32'd0);
    end
    // Release with a new command pending: it must not be taken on the same edge.
    out_ready = 1'b1; in_valid = 1'b1; a = 8'h05; b = 8'h06; sel = 4'd0;
    @(posedge clk);
    @(negedge clk);
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_release_valid", {31'd0, out_valid}, 32'd1);
    check("post_release_out", {24'd0, out}, 32'h0B);

    // Reset on the 4th EXEC cycle of a MUL.
    @(negedge clk);
    in_valid = 1'b1; a = 8'h0A; b = 8'h02; sel = 4'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out", {24'd0, out}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef ALU_FLAGS_EN
    check("midrst_carry", {31'd0, out_carry}, 32'd0);
    check("midrst_zero", {31'd0, out_zero}, 32'd0);
`endif
    rst = 1'b0;
    ready_leak = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) ready_leak = 1'b1;
    end
    check("midrst_no_result", {31'd0, ready_leak}, 32'd0);
    run_op(8'h01, 8'h01, 4'd0, r, lat);
    check("after_rst_add", {24'd0, r}, 32'h02);
    check("after_rst_latency", lat, 32'd1);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
